// File: rtl/pll_mdrp_ctrl.sv
// -----------------------------------------------------------------------------
// pll_mdrp_ctrl
//
// Initiator for the PLL dynamic-reconfiguration (MDRP) port. It runs one read
// or write burst per request. Write bursts end with a PLL reset pulse followed
// by a wait for lock, which is bounded by a timeout.
//
// Ports
//   clk        in   block clock; the same net drives the PLL mdclk
//   reset_n    in   asynchronous active-low reset
//   req        in   start request, sampled only in IDLE
//   wr         in   1 = write burst, 0 = read burst (latched with req)
//   addr[7:0]  in   start register address (latched with req)
//   len[3:0]   in   burst length minus one (latched with req)
//   wdata[7:0] in   write byte, valid in every write XFER cycle
//   wdata_rd   out  wdata consumed this cycle; the source advances
//   rdata[7:0] out  read byte
//   rdata_vld  out  rdata valid this cycle
//   busy       out  high while not in IDLE
//   done       out  one-cycle pulse at burst completion
//   timeout    out  sticky: lock not regained; cleared by next accepted req
//   pll_reset  out  active-high PLL reset
//   lock       in   PLL lock (asynchronous, synchronized internally)
//   mdopc[1:0] out  MDRP opcode: 00 NOP, 01 WRITE, 10 READ, 11 ADDR-load
//   mdainc     out  PLL address pointer post-increment
//   mdwdi[7:0] out  write data or address
//   mdrdo[7:0] in   read data, valid the cycle after a READ opcode
//   dbg_state  out  current FSM state, for debug and checkers
//
// Handshake: req is a level sampled only while IDLE and is not queued. There is
// no back-pressure on the write stream: wdata must hold the current byte in
// every write XFER cycle, and wdata_rd=1 marks the cycle in which that byte is
// taken, so the source moves to the next byte on that clock edge.
// -----------------------------------------------------------------------------
module pll_mdrp_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] wdata,
  output logic       wdata_rd,
  output logic [7:0] rdata,
  output logic       rdata_vld,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       pll_reset,
  input  logic       lock,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  output logic [2:0] dbg_state
);

  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] OPC_NOP   = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_READ  = 2'b10;
  localparam logic [1:0] OPC_ADDR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_XFER,
    S_DRAIN,
    S_RST,
    S_WAIT_LOCK,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tmr_q, tmr_d;
  logic        tmo_q, tmo_d;
  logic        lock_s1_q, lock_s2_q;
  logic        rv1_q, rv2_q;
  logic [7:0]  rdata_q;

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    mdopc     = OPC_NOP;
    mdainc    = 1'b0;
    mdwdi     = 8'h00;
    wdata_rd  = 1'b0;
    pll_reset = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = wr;
          addr_d  = addr;
          cnt_d   = len;
          tmo_d   = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        mdopc   = OPC_ADDR;
        mdwdi   = addr_q;
        state_d = S_XFER;
      end
      S_XFER: begin
        // The pointer is incremented after every byte except the last one.
        mdainc = (cnt_q != 4'd0);
        if (wr_q) begin
          mdopc    = OPC_WRITE;
          mdwdi    = wdata;
          wdata_rd = 1'b1;
        end else begin
          mdopc = OPC_READ;
        end
        if (cnt_q == 4'd0) begin
          state_d = wr_q ? S_RST : S_DRAIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DRAIN: begin
        // Leave once the last READ has moved through both pipeline stages.
        if (!rv1_q && !rv2_q) begin
          state_d = S_DONE;
        end
      end
      S_RST: begin
        pll_reset = 1'b1;
        if (tmr_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over the timeout in the final cycle.
        if (lock_s2_q) begin
          state_d = S_DONE;
        end else if (tmr_q == LOCK_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A single timer serves both RST and WAIT_LOCK. It restarts from zero on
    // every state change, so each timed state counts from its own entry cycle.
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      tmr_d = 16'd0;
    end else begin
      tmr_d = tmr_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= 8'h00;
      cnt_q     <= 4'd0;
      tmr_q     <= 16'd0;
      tmo_q     <= 1'b0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      rv1_q     <= 1'b0;
      rv2_q     <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      tmo_q     <= tmo_d;
      lock_s1_q <= lock;
      lock_s2_q <= lock_s1_q;
      // Stage 1 marks "a READ was issued last cycle", so mdrdo is valid now.
      // Stage 2 marks "rdata holds that byte".
      rv1_q     <= (state_q == S_XFER) && !wr_q;
      rv2_q     <= rv1_q;
      if (rv1_q) begin
        rdata_q <= mdrdo;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign timeout   = tmo_q;
  assign rdata     = rdata_q;
  assign rdata_vld = rv2_q;
  assign dbg_state = state_q;

endmodule
